// File: rtl/byte_serializer_if.sv
// Handshake bundle for byte_serializer: word-wide input side and byte-wide output side.
// The slave modport is the serializer's view; master is the driver/consumer view.
interface byte_serializer_if;
    logic [127:0] in_word;
    logic [3:0]   in_len;
    logic         in_valid;
    logic         in_ready;
    logic         abort;
    logic [7:0]   out_byte;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic [3:0]   sel;
    logic         busy;

    modport slave (
        input  in_word, in_len, in_valid, abort, out_ready,
        output in_ready, out_byte, out_valid, out_last, sel, busy
    );

    modport master (
        output in_word, in_len, in_valid, abort, out_ready,
        input  in_ready, out_byte, out_valid, out_last, sel, busy
    );
endinterface

// File: rtl/byte_serializer.sv
// Steps the 128-to-8 byte mux through a held word, presenting each byte on a
// valid/ready stream with GAP idle cycles between accepted non-last bytes.

// Plain 16:1 byte mux on the held word; byte k sits at data[8k+7:8k].
module byte_mux_128to8 (
    input  logic [127:0] data,
    input  logic [3:0]   sel,
    output logic [7:0]   y
);
    assign y = data[{sel, 3'b000} +: 8];
endmodule

// state | meaning
// IDLE  | no word held, in_ready high unless abort or reset
// SEND  | byte at sel presented with out_valid high
// WAIT  | idle gap after an accepted non-last byte, gap_cnt counts down to 0
module byte_serializer #(
    parameter int GAP = 0
) (
    input  logic             clk,
    input  logic             nRst,
    byte_serializer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

    localparam logic [7:0] GAP_LOAD = 8'(GAP - 1);

    state_t         state_q, state_d;
    logic [3:0]     sel_q, sel_d;
    logic [3:0]     len_q, len_d;
    logic [7:0]     gap_cnt_q, gap_cnt_d;
    logic [127:0]   word_q, word_d;

    assign bus.in_ready  = (state_q == IDLE) && !bus.abort && nRst;
    assign bus.out_valid = (state_q == SEND);
    assign bus.out_last  = (state_q == SEND) && (sel_q == len_q);
    assign bus.busy      = (state_q != IDLE);
    assign bus.sel       = sel_q;

    byte_mux_128to8 u_mux (
        .data (word_q),
        .sel  (sel_q),
        .y    (bus.out_byte)
    );

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        len_d     = len_q;
        gap_cnt_d = gap_cnt_q;
        word_d    = word_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid && bus.in_ready) begin
                    word_d  = bus.in_word;
                    len_d   = bus.in_len;
                    sel_d   = 4'd0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (bus.out_ready) begin
                    if (sel_q == len_q) begin
                        state_d = IDLE;
                        sel_d   = 4'd0;
                    end else begin
                        sel_d = sel_q + 4'd1;
                        if (GAP != 0) begin
                            gap_cnt_d = GAP_LOAD;
                            state_d   = WAIT;
                        end
                    end
                end
            end
            WAIT: begin
                if (gap_cnt_q == 8'd0) begin
                    state_d = SEND;
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Abort overrides everything; a byte handshaking in the same cycle is dropped.
        if (bus.abort) begin
            state_d = IDLE;
            sel_d   = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!nRst) begin
            state_q   <= IDLE;
            sel_q     <= 4'd0;
            len_q     <= 4'd0;
            gap_cnt_q <= 8'd0;
            word_q    <= 128'd0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            len_q     <= len_d;
            gap_cnt_q <= gap_cnt_d;
            word_q    <= word_d;
        end
    end
endmodule

// File: doc/byte_serializer.md
# byte_serializer

Sequencer for the 128-to-8 byte mux. It accepts a 128-bit word with a byte count, holds the word in a register, and steps the mux select from byte 0 upward. Each selected byte is presented on a valid/ready byte stream, with optional idle gap cycles between bytes. It sits between word-wide producers and byte-wide consumers such as the UART transmit path.

## Interface
- GAP, 0: minimum idle cycles inserted after each accepted non-last byte; legal range 0..255.
- clk  in  1  system clock; all state changes on the rising edge.
- nRst  in  1  reset, synchronous, active-low.
- in_word  in  128  word to send; byte k is in_word[8k+7:8k].
- in_len  in  4  index of the last byte to send (bytes sent = in_len+1, i.e. 1..16).
- in_valid  in  1  in_word/in_len valid.
- in_ready  out  1  block can accept a word this cycle.
- abort  in  1  synchronous abort of the current word.
- out_byte  out  8  current byte (mux output of the held word at sel).
- out_valid  out  1  out_byte valid.
- out_ready  in  1  consumer accepts out_byte.
- out_last  out  1  out_byte is the final byte of the word.
- sel  out  4  current mux select (byte index).
- busy  out  1  high in any state other than IDLE.

## Operation
- The block instantiates the existing mux module. Its inputs are the held word register and sel; out_byte is the mux output.
- States: IDLE, SEND, WAIT.
- IDLE
  - in_ready = 1 when abort = 0 and nRst = 1.
  - On in_valid && in_ready: capture in_word into word_r and in_len into len_r, set sel <= 0, go to SEND.
- SEND
  - out_valid = 1.
  - On out_ready with sel == len_r: go to IDLE; sel <= 0.
  - On out_ready with sel < len_r: sel <= sel+1. If GAP == 0, stay in SEND. Otherwise load gap_cnt <= GAP-1 and go to WAIT.
  - Without out_ready: hold state. sel, out_byte and out_last stay stable.
- WAIT
  - out_valid = 0.
  - When gap_cnt == 0, go to SEND; otherwise decrement gap_cnt.
- out_last = out_valid && (sel == len_r).
- Abort has priority over all other inputs:
  - In any state, abort = 1 sends the next state to IDLE with sel <= 0.
  - A byte with out_ready high in the same cycle counts as not transferred.
  - No word is accepted in an abort cycle.
- word_r and len_r change only on a capture. in_word/in_len changes while busy are ignored.
- There is no overlap between words. A new word can only be accepted in IDLE.
- Counter widths: sel is 4 bits and gap_cnt is 8 bits. sel never wraps, because the terminal compare with len_r ends the word first.

## Timing
- Reset: while nRst is sampled low at an edge, the next state is
  - state IDLE, sel 0, word_r 0, len_r 0, gap_cnt 0;
  - out_valid 0, out_last 0, busy 0, out_byte 0x00;
  - in_ready is held 0 while nRst = 1'b0.
- Reset dominates abort and in_valid. Reset mid-word discards the word.
- Latency: a word accepted at edge N presents byte 0 valid in cycle N+1.
- Throughput with GAP = 0 and out_ready held high: one byte per cycle. After the last byte is accepted, IDLE follows for one cycle (in_ready high). The per-word overhead is 1 cycle.
- With GAP = g > 0 and out_ready high, consecutive bytes are valid every g+1 cycles. There is no gap after the last byte.
- out_valid never drops without a handshake except on abort or reset.
- sel and out_byte are registered or derived from registered state only. They have no combinational path from out_ready.

## Test plan
- Reset: hold nRst low for 3 cycles with in_valid = 1 → in_ready = 0, out_valid = 0, busy = 0, sel = 0. Release → in_ready = 1, and no word was captured.
- Full word: GAP = 0, in_word bytes 0x00..0x0F (byte k = k), in_len = 15, out_ready = 1 → 16 consecutive valid cycles carrying 0x00..0x0F. out_last is high only on 0x0F. in_ready = 1 on the following cycle.
- Backpressure: in_len = 3, bytes 0xAA, 0xBB, 0xCC, 0xDD. Hold out_ready low for 5 cycles while byte 1 is presented → out_byte = 0xBB, sel = 1, out_valid = 1 throughout. The remaining bytes follow in order once out_ready rises.
- Single byte: in_len = 0, byte 0 = 0x5A → one valid cycle with out_byte = 0x5A and out_last = 1, then IDLE.
- Gap: GAP = 3 instance, in_len = 2, out_ready = 1 → out_valid is high at cycles t, t+4, t+8 and low in between. out_last is at t+8.
- Abort: during byte 5 of a 16-byte word, assert abort together with out_ready → IDLE next cycle, out_valid = 0, sel = 0, busy = 0. The next word starts again at byte 0 with the new data.
